// File: rtl/text_term_pkg.sv
// Shared character constants and engine state encoding for the text terminal.
package text_term_pkg;
  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;
  localparam logic [7:0] LF       = 8'h0A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } term_state_e;
endpackage

// File: rtl/text_cursor_engine_walker.sv
// Address walker that sweeps one row or the whole grid, row-major, one cell per step.
module grid_clear_walker #(
  parameter int COLS        = 32,
  parameter int ROWS        = 4,
  parameter int RESET_WHOLE = 1,
  localparam int COL_W = $clog2(COLS),
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             whole_grid,
  input  logic [ROW_W-1:0] start_row,
  input  logic             step,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             done
);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             whole_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q   <= '0;
      col_q   <= '0;
      whole_q <= (RESET_WHOLE != 0);
    end else if (start) begin
      row_q   <= start_row;
      col_q   <= '0;
      whole_q <= whole_grid;
    end else if (step) begin
      // Wraps compare against the grid limits, never rely on natural overflow.
      if (col_q == COL_MAX) begin
        col_q <= '0;
        if (whole_q) row_q <= (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign done = (col_q == COL_MAX) && (!whole_q || (row_q == ROW_MAX));
endmodule

// File: rtl/text_cursor_engine.sv
// Turns a received byte stream into character-RAM writes and tracks the live cursor.
// Handshake: rx_valid is a one-cycle strobe accepted only while busy is low; a strobe while busy is dropped and sets overflow.
module text_cursor_engine
  import text_term_pkg::*;
#(
  parameter int         COLS           = 32,
  parameter int         ROWS           = 4,
  parameter logic [7:0] NL_CODE        = 8'h0D,
  parameter logic [7:0] BS_CODE        = 8'h08,
  parameter logic [7:0] FF_CODE        = 8'h0C,
  parameter int         ROW_CLEAR      = 1,
  parameter int         CLEAR_ON_RESET = 1,
  localparam int COL_W = $clog2(COLS),
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             clr_ovf,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy,
  output logic             overflow
);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam term_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLR_ALL : IDLE;

  term_state_e      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, row_adv;
  logic [COL_W-1:0] col_q, col_d;
  logic             wr_en_q, wr_en_d;
  logic [ROW_W-1:0] wr_row_q, wr_row_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             ovf_q, ovf_d;

  logic             walk_start, walk_whole, walk_done;
  logic [ROW_W-1:0] walk_start_row, walk_row;
  logic [COL_W-1:0] walk_col;

  grid_clear_walker #(
    .COLS(COLS), .ROWS(ROWS), .RESET_WHOLE(CLEAR_ON_RESET)
  ) u_walker (
    .clk(clk), .reset(reset),
    .start(walk_start), .whole_grid(walk_whole), .start_row(walk_start_row),
    .step(state_q != IDLE),
    .row(walk_row), .col(walk_col), .done(walk_done)
  );

  assign row_adv = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    col_d          = col_q;
    wr_en_d        = 1'b0;
    wr_row_d       = wr_row_q;
    wr_col_d       = wr_col_q;
    wr_data_d      = wr_data_q;
    ovf_d          = ovf_q;
    walk_start     = 1'b0;
    walk_whole     = 1'b0;
    walk_start_row = '0;

    if (clr_ovf) ovf_d = 1'b0;
    if (rx_valid && (state_q != IDLE)) ovf_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if ((rx_data >= PRINT_LO) && (rx_data <= PRINT_HI)) begin
            wr_en_d   = 1'b1;
            wr_row_d  = row_q;
            wr_col_d  = col_q;
            wr_data_d = rx_data;
            if (col_q == COL_MAX) begin
              col_d = '0;
              row_d = row_adv;
              if (ROW_CLEAR != 0) begin
                state_d        = CLR_ROW;
                walk_start     = 1'b1;
                walk_start_row = row_adv;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if ((rx_data == NL_CODE) || (rx_data == LF)) begin
            col_d = '0;
            row_d = row_adv;
            if (ROW_CLEAR != 0) begin
              state_d        = CLR_ROW;
              walk_start     = 1'b1;
              walk_start_row = row_adv;
            end
          end else if (rx_data == BS_CODE) begin
            // Backspace stops at column 0; it never reverse-wraps to the previous row.
            if (col_q != '0) begin
              col_d     = col_q - 1'b1;
              wr_en_d   = 1'b1;
              wr_row_d  = row_q;
              wr_col_d  = col_q - 1'b1;
              wr_data_d = SPACE;
            end
          end else if (rx_data == FF_CODE) begin
            row_d      = '0;
            col_d      = '0;
            state_d    = CLR_ALL;
            walk_start = 1'b1;
            walk_whole = 1'b1;
          end
        end
      end
      CLR_ROW, CLR_ALL: begin
        wr_en_d   = 1'b1;
        wr_row_d  = walk_row;
        wr_col_d  = walk_col;
        wr_data_d = SPACE;
        if (walk_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      row_q     <= '0;
      col_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_en_q   <= wr_en_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_row   = wr_row_q;
  assign wr_col   = wr_col_q;
  assign wr_data  = wr_data_q;
  assign cur_row  = row_q;
  assign cur_col  = col_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
endmodule

// File: tb/tb_text_cursor_engine.sv
// Directed bench: a 32x4 engine with row/reset clearing and a 40x3 engine without clearing.
module tb_text_cursor_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;

  // 32x4, ROW_CLEAR=1, CLEAR_ON_RESET=1
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0, clr_ovf = 1'b0;
  logic       wr_en, busy, overflow;
  logic [1:0] wr_row, cur_row;
  logic [4:0] wr_col, cur_col;
  logic [7:0] wr_data;

  // 40x3, ROW_CLEAR=0, CLEAR_ON_RESET=0
  logic [7:0] rx_data2 = 8'h00;
  logic       rx_valid2 = 1'b0, clr_ovf2 = 1'b0;
  logic       wr_en2, busy2, overflow2;
  logic [1:0] wr_row2, cur_row2;
  logic [5:0] wr_col2, cur_col2;
  logic [7:0] wr_data2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  text_cursor_engine dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .clr_ovf(clr_ovf),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .overflow(overflow)
  );

  text_cursor_engine #(
    .COLS(40), .ROWS(3), .ROW_CLEAR(0), .CLEAR_ON_RESET(0)
  ) dut2 (
    .clk(clk), .reset(reset), .rx_data(rx_data2), .rx_valid(rx_valid2), .clr_ovf(clr_ovf2),
    .wr_en(wr_en2), .wr_row(wr_row2), .wr_col(wr_col2), .wr_data(wr_data2),
    .cur_row(cur_row2), .cur_col(cur_col2), .busy(busy2), .overflow(overflow2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send1(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    rx_data2 = b;
    rx_valid2 = 1'b1;
    tick();
    rx_valid2 = 1'b0;
  endtask

  // Runs dut until idle, counting space writes; a timeout counts as a failure.
  task automatic wait_idle(input string tag, input int exp_writes);
    int n = 0;
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
      if (wr_en && wr_data == 8'h20) n++;
    end
    chk({tag, "_timeout"}, 32'(busy), 32'd0);
    chk({tag, "_writes"}, n, exp_writes);
  endtask

  task automatic check_full_clear(input string tag);
    for (int i = 0; i < 128; i++) begin
      tick();
      chk({tag, "_wr_en"}, 32'(wr_en), 32'd1);
      chk({tag, "_addr"}, {wr_row, wr_col}, 32'(i));
      chk({tag, "_data"}, 32'(wr_data), 32'h20);
      chk({tag, "_busy"}, 32'(busy), (i == 127) ? 32'd0 : 32'd1);
    end
    chk({tag, "_cursor"}, {cur_row, cur_col}, 32'd0);
  endtask

  initial begin
    // Reset values while reset is held
    tick();
    tick();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", {wr_row, wr_col, wr_data}, 32'd0);
    chk("rst_cursor", {cur_row, cur_col}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    reset = 1'b0;
    check_full_clear("boot_clear");

    // Printable at (0,0)
    send1(8'h41);
    chk("pr_wr_en", 32'(wr_en), 32'd1);
    chk("pr_addr", {wr_row, wr_col}, 32'd0);
    chk("pr_data", 32'(wr_data), 32'h41);
    chk("pr_cursor", {cur_row, cur_col}, {2'd0, 5'd1});
    tick();
    chk("pr_no_write", 32'(wr_en), 32'd0);
    chk("pr_hold_data", 32'(wr_data), 32'h41);

    // Three newlines, each clearing the destination row
    send1(8'h0D);
    chk("nl_no_write", 32'(wr_en), 32'd0);
    chk("nl_cursor", {cur_row, cur_col}, {2'd1, 5'd0});
    chk("nl_busy", 32'(busy), 32'd1);
    wait_idle("nl1", 32);
    send1(8'h0A);
    wait_idle("nl2", 32);
    send1(8'h0D);
    wait_idle("nl3", 32);
    chk("at_row3", {cur_row, cur_col}, {2'd3, 5'd0});
    for (int i = 0; i < 31; i++) send1(8'h61);
    chk("at_3_31", {cur_row, cur_col}, {2'd3, 5'd31});

    // Bottom-right printable: wraps to (0,0) and clears row 0
    send1(8'h5A);
    chk("br_wr", {wr_en, wr_row, wr_col, wr_data}, {1'b1, 2'd3, 5'd31, 8'h5A});
    chk("br_cursor", {cur_row, cur_col}, 32'd0);
    chk("br_busy", 32'(busy), 32'd1);
    for (int j = 0; j < 32; j++) begin
      tick();
      chk("row0_clr", {wr_en, wr_row, wr_col, wr_data}, {1'b1, 2'd0, 5'(j), 8'h20});
      chk("row0_busy", 32'(busy), (j == 31) ? 32'd0 : 32'd1);
    end

    // Backspace mid-row and at column 0
    send1(8'h0D);
    wait_idle("nl4", 32);
    for (int i = 0; i < 5; i++) send1(8'h62);
    chk("at_1_5", {cur_row, cur_col}, {2'd1, 5'd5});
    send1(8'h08);
    chk("bs_wr", {wr_en, wr_row, wr_col, wr_data}, {1'b1, 2'd1, 5'd4, 8'h20});
    chk("bs_cursor", {cur_row, cur_col}, {2'd1, 5'd4});
    send1(8'h0D);
    wait_idle("nl5", 32);
    send1(8'h08);
    chk("bs0_no_write", 32'(wr_en), 32'd0);
    chk("bs0_cursor", {cur_row, cur_col}, {2'd2, 5'd0});
    send1(8'h01);
    chk("ign_no_write", 32'(wr_en), 32'd0);
    chk("ign_cursor", {cur_row, cur_col}, {2'd2, 5'd0});

    // Overflow during a row clear
    send1(8'h0D);
    tick();
    chk("ovf_pre", 32'(overflow), 32'd0);
    rx_data = 8'h42;
    rx_valid = 1'b1;
    tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_drop", {wr_en, wr_row, wr_col, wr_data}, {1'b1, 2'd3, 5'd1, 8'h20});
    clr_ovf = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    rx_valid = 1'b0;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    wait_idle("ovf_rest", 28);
    chk("ovf_cursor", {cur_row, cur_col}, {2'd3, 5'd0});

    // Form feed
    send1(8'h0C);
    chk("ff_no_write", 32'(wr_en), 32'd0);
    chk("ff_cursor", {cur_row, cur_col}, 32'd0);
    chk("ff_busy", 32'(busy), 32'd1);
    check_full_clear("ff_clear");

    // 40x3 engine: wrap from (2,0) across a full row, then DEL ignored
    send2(8'h0A);
    send2(8'h0D);
    chk("d2_at_2_0", {cur_row2, cur_col2, busy2}, {2'd2, 6'd0, 1'b0});
    for (int i = 0; i < 40; i++) begin
      send2(8'h30 + 8'(i));
      chk("d2_wr", {wr_en2, wr_row2, wr_col2, wr_data2}, {1'b1, 2'd2, 6'(i), 8'h30 + 8'(i)});
    end
    chk("d2_wrap", {cur_row2, cur_col2}, 32'd0);
    chk("d2_busy", 32'(busy2), 32'd0);
    send2(8'h7F);
    chk("d2_del_no_write", 32'(wr_en2), 32'd0);
    chk("d2_del_cursor", {cur_row2, cur_col2}, 32'd0);
    chk("d2_ovf", 32'(overflow2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
